// File: rtl/iram_pkg.sv
// Shared definitions for the IRAM arbiter: default geometry, FSM states, port ids.
package iram_pkg;

  localparam int unsigned IRAM_ADDR_W = 9;
  localparam int unsigned IRAM_DATA_W = 9;
  localparam int unsigned IRAM_DEPTH  = 512;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_t;

endpackage

// File: rtl/iram_rr_arb.sv
// Two-way grant logic for fetch/loader: loader-only while booting, then
// round-robin (or loader-fixed priority) with a last-granted pointer.
module iram_rr_arb
  import iram_pkg::*;
#(
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic f_req,
  input  logic l_req,
  output logic f_gnt,
  output logic l_gnt
);

  port_t last;

  // Combinational grant from current requests and last-granted pointer.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!run) begin
      l_gnt = l_req;
    end else if (FIXED_PRI != 0) begin
      l_gnt = l_req;
      f_gnt = f_req & ~l_req;
    end else if (f_req && l_req) begin
      if (last == PORT_F) l_gnt = 1'b1;
      else                f_gnt = 1'b1;
    end else begin
      f_gnt = f_req;
      l_gnt = l_req;
    end
  end

  // Last-granted pointer moves only when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last <= PORT_F;
    else if (f_gnt) last <= PORT_F;
    else if (l_gnt) last <= PORT_L;
  end

endmodule

// File: rtl/iram_arbiter.sv
// Shares the single-port IRAM between the core fetch port and the program
// loader, sequencing boot (loader only) before enabling the core.
module iram_arbiter
  import iram_pkg::*;
#(
  parameter int unsigned ADDR_W    = IRAM_ADDR_W,
  parameter int unsigned DATA_W    = IRAM_DATA_W,
  parameter int unsigned DEPTH     = IRAM_DEPTH,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              load_done,
  output logic              core_en,
  output logic              addr_err,
  output logic              iram_read,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] iram_din,
  input  logic [DATA_W-1:0] iram_dout
);

  state_t            state, state_d;
  logic              gnt_any, gnt_wr, gnt_oor;
  logic [ADDR_W-1:0] gnt_addr;
  logic              s1_rd, s1_oor, s2_oor;
  port_t             s1_port;
  logic [DATA_W-1:0] rd_live, f_hold, l_hold;

  iram_rr_arb #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state == ST_RUN),
    .f_req (f_req),
    .l_req (l_req),
    .f_gnt (f_gnt),
    .l_gnt (l_gnt)
  );

  // Selected access for this cycle; fetch is read-only so only a loader grant can write.
  always_comb begin
    gnt_any  = f_gnt | l_gnt;
    gnt_addr = l_gnt ? l_addr : f_addr;
    gnt_wr   = l_gnt & l_we;
    gnt_oor  = (32'(gnt_addr) >= DEPTH);
  end

  // Boot sequencing: leave BOOT once the loader is done and idle this cycle.
  always_comb begin
    state_d = state;
    if (state == ST_BOOT && load_done && !l_gnt) state_d = ST_RUN;
  end

  // State register; core_en follows the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BOOT;
      core_en <= 1'b0;
    end else begin
      state   <= state_d;
      core_en <= (state_d == ST_RUN);
    end
  end

  // Registered IRAM drive; out-of-range writes are turned into harmless reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iram_read <= 1'b1;
      iram_addr <= '0;
      iram_din  <= '0;
    end else begin
      iram_read <= 1'b1;
      if (gnt_any) iram_addr <= gnt_addr;
      if (gnt_wr && !gnt_oor) begin
        iram_read <= 1'b0;
        iram_din  <= l_wdata;
      end
    end
  end

  // Response pipe: stage 1 aligns with IRAM drive, stage 2 with iram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd    <= 1'b0;
      s1_port  <= PORT_F;
      s1_oor   <= 1'b0;
      s2_oor   <= 1'b0;
      addr_err <= 1'b0;
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      s1_rd    <= gnt_any & ~gnt_wr;
      s1_port  <= l_gnt ? PORT_L : PORT_F;
      s1_oor   <= gnt_oor;
      addr_err <= gnt_any & gnt_oor;
      s2_oor   <= s1_oor;
      f_rvalid <= s1_rd && (s1_port == PORT_F);
      l_rvalid <= s1_rd && (s1_port == PORT_L);
    end
  end

  // iram_dout is already the IRAM's output register, so it is passed through
  // during the rvalid cycle and captured into a hold register for later cycles.
  always_comb begin
    rd_live = s2_oor ? '0 : iram_dout;
    f_rdata = f_rvalid ? rd_live : f_hold;
    l_rdata = l_rvalid ? rd_live : l_hold;
  end

  // Hold last returned data per port between rvalid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_hold <= '0;
      l_hold <= '0;
    end else begin
      if (f_rvalid) f_hold <= rd_live;
      if (l_rvalid) l_hold <= rd_live;
    end
  end

endmodule

// File: tb/tb_iram_arbiter.sv
// Directed bench for iram_arbiter: a round-robin instance with DEPTH=256 and a
// fixed-priority instance share all inputs; each has its own IRAM model.
module tb_iram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       f_req, l_req, l_we, load_done;
  logic [8:0] f_addr, l_addr, l_wdata;

  logic       rr_f_gnt, rr_f_rvalid, rr_l_gnt, rr_l_rvalid, rr_core_en, rr_addr_err, rr_iram_read;
  logic [8:0] rr_f_rdata, rr_l_rdata, rr_iram_addr, rr_iram_din, rr_iram_dout;
  logic       fx_f_gnt, fx_f_rvalid, fx_l_gnt, fx_l_rvalid, fx_core_en, fx_addr_err, fx_iram_read;
  logic [8:0] fx_f_rdata, fx_l_rdata, fx_iram_addr, fx_iram_din, fx_iram_dout;

  logic [8:0] rr_mem [512];
  logic [8:0] fx_mem [512];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iram_arbiter #(.DEPTH(256), .FIXED_PRI(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(rr_f_gnt), .f_rvalid(rr_f_rvalid), .f_rdata(rr_f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(rr_l_gnt), .l_rvalid(rr_l_rvalid), .l_rdata(rr_l_rdata),
    .load_done(load_done), .core_en(rr_core_en), .addr_err(rr_addr_err),
    .iram_read(rr_iram_read), .iram_addr(rr_iram_addr), .iram_din(rr_iram_din), .iram_dout(rr_iram_dout)
  );

  iram_arbiter #(.FIXED_PRI(1)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(fx_f_gnt), .f_rvalid(fx_f_rvalid), .f_rdata(fx_f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(fx_l_gnt), .l_rvalid(fx_l_rvalid), .l_rdata(fx_l_rdata),
    .load_done(load_done), .core_en(fx_core_en), .addr_err(fx_addr_err),
    .iram_read(fx_iram_read), .iram_addr(fx_iram_addr), .iram_din(fx_iram_din), .iram_dout(fx_iram_dout)
  );

  // Synchronous single-port IRAM models.
  always @(posedge clk) begin
    if (!rr_iram_read) rr_mem[rr_iram_addr] <= rr_iram_din;
    else               rr_iram_dout <= rr_mem[rr_iram_addr];
    if (!fx_iram_read) fx_mem[fx_iram_addr] <= fx_iram_din;
    else               fx_iram_dout <= fx_mem[fx_iram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    rst_n = 1'b0; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; load_done = 1'b0;
    f_addr = '0; l_addr = '0; l_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (rr_f_gnt !== 1'b0 || rr_l_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", rr_f_gnt, rr_l_gnt); end
    total++; if (rr_f_rvalid !== 1'b0 || rr_l_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b%b exp=00", rr_f_rvalid, rr_l_rvalid); end
    total++; if (rr_core_en !== 1'b0 || rr_addr_err !== 1'b0) begin bad++; $display("FAIL rst_core_err got=%b%b exp=00", rr_core_en, rr_addr_err); end
    total++; if (rr_f_rdata !== 9'h0 || rr_l_rdata !== 9'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", rr_f_rdata, rr_l_rdata); end
    total++; if (rr_iram_read !== 1'b1 || rr_iram_addr !== 9'h0 || rr_iram_din !== 9'h0) begin
      bad++; $display("FAIL rst_iram got=%b/%h/%h exp=1/0/0", rr_iram_read, rr_iram_addr, rr_iram_din); end
  endtask

  task automatic test_boot_no_fetch;
    @(negedge clk);
    f_req = 1'b1; f_addr = 9'd5;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++; if (rr_f_gnt !== 1'b0) begin bad++; $display("FAIL boot_f_gnt cyc=%0d got=%b exp=0", i, rr_f_gnt); end
      total++; if (rr_core_en !== 1'b0 || rr_iram_read !== 1'b1) begin
        bad++; $display("FAIL boot_idle cyc=%0d got=%b%b exp=01", i, rr_core_en, rr_iram_read); end
      @(negedge clk);
    end
    f_req = 1'b0;
  endtask

  task automatic test_boot_load;
    logic [8:0] wa [4];
    logic [8:0] wd [4];
    wa[0] = 9'd1;   wd[0] = 9'h1A5;
    wa[1] = 9'd225; wd[1] = 9'h0F0;
    wa[2] = 9'd224; wd[2] = 9'h033;
    wa[3] = 9'd223; wd[3] = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = wa[i]; l_wdata = wd[i];
      #1;
      total++; if (rr_l_gnt !== 1'b1) begin bad++; $display("FAIL boot_l_gnt i=%0d got=%b exp=1", i, rr_l_gnt); end
      @(negedge clk);
      total++; if (rr_iram_read !== 1'b0 || rr_iram_addr !== wa[i] || rr_iram_din !== wd[i]) begin
        bad++; $display("FAIL boot_write i=%0d got=%b/%h/%h exp=0/%h/%h", i, rr_iram_read, rr_iram_addr, rr_iram_din, wa[i], wd[i]); end
    end
    l_req = 1'b0; l_we = 1'b0;
    @(negedge clk);
    total++; if (rr_iram_read !== 1'b1 || rr_iram_addr !== 9'd223 || rr_iram_din !== 9'h1FF) begin
      bad++; $display("FAIL boot_idle_hold got=%b/%h/%h exp=1/0df/1ff", rr_iram_read, rr_iram_addr, rr_iram_din); end
    // Read back @225 while load_done is raised: the grant keeps the FSM in BOOT.
    l_req = 1'b1; l_addr = 9'd225; load_done = 1'b1;
    #1;
    total++; if (rr_l_gnt !== 1'b1) begin bad++; $display("FAIL boot_rd_gnt got=%b exp=1", rr_l_gnt); end
    @(negedge clk);
    l_req = 1'b0;
    total++; if (rr_core_en !== 1'b0 || rr_l_rvalid !== 1'b0) begin
      bad++; $display("FAIL boot_stay got=%b%b exp=00", rr_core_en, rr_l_rvalid); end
    @(negedge clk);
    load_done = 1'b0;
    total++; if (rr_l_rvalid !== 1'b1 || rr_l_rdata !== 9'h0F0) begin
      bad++; $display("FAIL boot_rdata got=%b/%h exp=1/0f0", rr_l_rvalid, rr_l_rdata); end
    total++; if (rr_core_en !== 1'b1) begin bad++; $display("FAIL core_en_rise got=%b exp=1", rr_core_en); end
    @(negedge clk);
    total++; if (rr_l_rvalid !== 1'b0 || rr_l_rdata !== 9'h0F0) begin
      bad++; $display("FAIL boot_rdata_hold got=%b/%h exp=0/0f0", rr_l_rvalid, rr_l_rdata); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] ea [4];
    logic [8:0] ed [4];
    ea[0] = 9'd225; ed[0] = 9'h0F0;
    ea[1] = 9'd224; ed[1] = 9'h033;
    ea[2] = 9'd223; ed[2] = 9'h1FF;
    ea[3] = 9'd222; ed[3] = 9'h0C3;
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        total++; if (rr_f_rvalid !== 1'b1 || rr_f_rdata !== ed[k-2]) begin
          bad++; $display("FAIL b2b_rdata k=%0d got=%b/%h exp=1/%h", k, rr_f_rvalid, rr_f_rdata, ed[k-2]); end
      end
      if (k < 4) begin
        f_req = 1'b1; f_addr = ea[k];
        #1;
        total++; if (rr_f_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt k=%0d got=%b exp=1", k, rr_f_gnt); end
      end else begin
        f_req = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (rr_f_rvalid !== 1'b0 || rr_f_rdata !== 9'h0C3) begin
      bad++; $display("FAIL b2b_tail got=%b/%h exp=0/0c3", rr_f_rvalid, rr_f_rdata); end
  endtask

  task automatic test_run_loader_read;
    l_req = 1'b1; l_we = 1'b0; l_addr = 9'd1;
    #1;
    total++; if (rr_l_gnt !== 1'b1 || rr_f_gnt !== 1'b0) begin bad++; $display("FAIL run_l_gnt got=%b%b exp=10", rr_l_gnt, rr_f_gnt); end
    @(negedge clk);
    l_req = 1'b0;
    @(negedge clk);
    total++; if (rr_l_rvalid !== 1'b1 || rr_l_rdata !== 9'h1A5) begin
      bad++; $display("FAIL run_l_rdata got=%b/%h exp=1/1a5", rr_l_rvalid, rr_l_rdata); end
    @(negedge clk);
  endtask

  task automatic test_contention;
    for (int k = 0; k < 6; k++) begin
      f_req = 1'b1; f_addr = 9'd2; l_req = 1'b1; l_we = 1'b0; l_addr = 9'd1;
      #1;
      total++; if (rr_f_gnt !== ((k % 2) == 0) || rr_l_gnt !== ((k % 2) == 1)) begin
        bad++; $display("FAIL rr_alt k=%0d got=%b%b exp=%b%b", k, rr_f_gnt, rr_l_gnt, (k % 2) == 0, (k % 2) == 1); end
      total++; if (fx_l_gnt !== 1'b1 || fx_f_gnt !== 1'b0) begin
        bad++; $display("FAIL fx_pri k=%0d got=%b%b exp=01", k, fx_f_gnt, fx_l_gnt); end
      @(negedge clk);
    end
    l_req = 1'b0;
    #1;
    total++; if (fx_f_gnt !== 1'b1 || rr_f_gnt !== 1'b1) begin
      bad++; $display("FAIL f_after_l got=%b%b exp=11", fx_f_gnt, rr_f_gnt); end
    @(negedge clk);
    f_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_out_of_range;
    l_req = 1'b1; l_we = 1'b1; l_addr = 9'd300; l_wdata = 9'h155;
    #1;
    total++; if (rr_l_gnt !== 1'b1) begin bad++; $display("FAIL oor_wr_gnt got=%b exp=1", rr_l_gnt); end
    @(negedge clk);
    l_req = 1'b0; l_we = 1'b0;
    total++; if (rr_addr_err !== 1'b1 || rr_iram_read !== 1'b1) begin
      bad++; $display("FAIL oor_wr got=%b/%b exp=1/1", rr_addr_err, rr_iram_read); end
    @(negedge clk);
    total++; if (rr_addr_err !== 1'b0 || rr_iram_read !== 1'b1) begin
      bad++; $display("FAIL oor_wr_after got=%b/%b exp=0/1", rr_addr_err, rr_iram_read); end
    f_req = 1'b1; f_addr = 9'd300;
    #1;
    total++; if (rr_f_gnt !== 1'b1) begin bad++; $display("FAIL oor_rd_gnt got=%b exp=1", rr_f_gnt); end
    @(negedge clk);
    f_req = 1'b0;
    total++; if (rr_addr_err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b exp=1", rr_addr_err); end
    @(negedge clk);
    total++; if (rr_f_rvalid !== 1'b1 || rr_f_rdata !== 9'h0 || rr_addr_err !== 1'b0) begin
      bad++; $display("FAIL oor_rd_data got=%b/%h/%b exp=1/000/0", rr_f_rvalid, rr_f_rdata, rr_addr_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    f_req = 1'b1; f_addr = 9'd100;
    #1;
    total++; if (rr_f_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b exp=1", rr_f_gnt); end
    @(negedge clk);
    f_req = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (rr_core_en !== 1'b0 || rr_addr_err !== 1'b0 || rr_f_rvalid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctl got=%b%b%b exp=000", rr_core_en, rr_addr_err, rr_f_rvalid); end
    total++; if (rr_iram_read !== 1'b1 || rr_iram_addr !== 9'h0 || rr_iram_din !== 9'h0) begin
      bad++; $display("FAIL mid_rst_iram got=%b/%h/%h exp=1/0/0", rr_iram_read, rr_iram_addr, rr_iram_din); end
    total++; if (rr_f_rdata !== 9'h0 || rr_l_rdata !== 9'h0) begin
      bad++; $display("FAIL mid_rst_rdata got=%h/%h exp=0/0", rr_f_rdata, rr_l_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (rr_f_rvalid !== 1'b0) begin bad++; $display("FAIL mid_no_rvalid got=%b exp=0", rr_f_rvalid); end
    f_req = 1'b1; f_addr = 9'd5;
    #1;
    total++; if (rr_f_gnt !== 1'b0 || rr_core_en !== 1'b0) begin
      bad++; $display("FAIL mid_boot got=%b%b exp=00", rr_f_gnt, rr_core_en); end
    @(negedge clk);
    f_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      rr_mem[i] = 9'h0;
      fx_mem[i] = 9'h0;
    end
    rr_mem[222] = 9'h0C3;
    rr_mem[300] = 9'h0AA;
    rr_mem[100] = 9'h077;
    test_reset();
    test_boot_no_fetch();
    test_boot_load();
    test_back_to_back();
    test_run_loader_read();
    test_contention();
    test_out_of_range();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
